// File: rtl/avalon_sdr.sv
// Avalon-MM read master: fetches up to 64 32-bit elements as 16-bit beats into a 2048-bit buffer.
// Optional build macro AVALON_SDR_CLEAR_ON_START_EN clears the buffer when a new block is loaded.
module avalon_sdr (
  input  logic          clk,
  input  logic          reset,
  input  logic          sdr_readstart,
  input  logic [31:0]   sdr_baseaddr,
  input  logic [29:0]   sdr_nelems,
  output logic [2047:0] sdr_readdata,
  output logic          sdr_readend,
  output logic [31:0]   avm_m0_address,
  output logic          avm_m0_read,
  input  logic [15:0]   avm_m0_readdata,
  input  logic          avm_m0_readdatavalid,
  input  logic          avm_m0_waitrequest
);

  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_e;

  state_e        state_q;
  logic [7:0]    halfTotal_q;
  logic [7:0]    issued_q;
  logic [7:0]    rcvd_q;
  logic [31:0]   addr_q;
  logic          read_q;
  logic          end_q;
  logic [2047:0] buf_q;

  logic [7:0]    halfTotal_d;
  logic [7:0]    issued_d;
  logic [7:0]    rcvd_d;
  logic          accept;
  logic          capture;

  // Element count is clamped to the 64-element buffer; each element is two half-word beats.
  always_comb begin
    halfTotal_d = (sdr_nelems > 30'd64) ? 8'd128 : {sdr_nelems[6:0], 1'b0};
    issued_d    = issued_q + 8'd1;
    rcvd_d      = rcvd_q + 8'd1;
    accept      = (state_q == READ) && read_q && !avm_m0_waitrequest;
    capture     = ((state_q == READ) || (state_q == DRAIN)) && avm_m0_readdatavalid
                  && (rcvd_q != halfTotal_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      halfTotal_q <= 8'd0;
      issued_q    <= 8'd0;
      rcvd_q      <= 8'd0;
      addr_q      <= 32'd0;
      read_q      <= 1'b0;
      end_q       <= 1'b0;
      buf_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sdr_readstart) state_q <= LOAD;
        end
        LOAD: begin
          halfTotal_q <= halfTotal_d;
          issued_q    <= 8'd0;
          rcvd_q      <= 8'd0;
          addr_q      <= sdr_baseaddr;
`ifdef AVALON_SDR_CLEAR_ON_START_EN
          buf_q       <= '0;
`endif
          if (halfTotal_d == 8'd0) begin
            state_q <= DONE;
            read_q  <= 1'b0;
            end_q   <= 1'b1;
          end else begin
            state_q <= READ;
            read_q  <= 1'b1;
          end
        end
        READ: begin
          // Address advances by one half-word per accepted read; it wraps modulo 2^32.
          if (accept) begin
            issued_q <= issued_d;
            if (issued_d == halfTotal_q) begin
              read_q  <= 1'b0;
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + 32'd2;
            end
          end
        end
        DRAIN: begin
          if (rcvd_q == halfTotal_q) begin
            state_q <= DONE;
            end_q   <= 1'b1;
          end
        end
        DONE: begin
          if (sdr_readstart) begin
            state_q <= LOAD;
            end_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Responses return in issue order, so the receive count is the destination slot.
      if (capture) begin
        buf_q[{rcvd_q[6:0], 4'b0000} +: 16] <= avm_m0_readdata;
        rcvd_q <= rcvd_d;
      end
    end
  end

  assign sdr_readdata   = buf_q;
  assign sdr_readend    = end_q;
  assign avm_m0_address = addr_q;
  assign avm_m0_read    = read_q;

endmodule

// File: tb/tb_avalon_sdr.sv
// Scoreboard bench for avalon_sdr: stimulus pushes expected addresses and completion records,
// a negedge monitor pops and compares them whenever the DUT issues a read or raises sdr_readend.
module tb_avalon_sdr;

  logic          clk = 1'b0;
  logic          reset;
  logic          sdr_readstart;
  logic [31:0]   sdr_baseaddr;
  logic [29:0]   sdr_nelems;
  logic [2047:0] sdr_readdata;
  logic          sdr_readend;
  logic [31:0]   avm_m0_address;
  logic          avm_m0_read;
  logic [15:0]   avm_m0_readdata;
  logic          avm_m0_readdatavalid;
  logic          avm_m0_waitrequest;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prevEnd = 1'b0;

  typedef struct {
    int          riseCyc;
    logic [63:0] lo64;
    int          slot;
    logic [15:0] slotVal;
    string       name;
  } endExp_t;

  logic [31:0] expAddrQ[$];
  endExp_t     endQ[$];

  avalon_sdr dut (
    .clk                  (clk),
    .reset                (reset),
    .sdr_readstart        (sdr_readstart),
    .sdr_baseaddr         (sdr_baseaddr),
    .sdr_nelems           (sdr_nelems),
    .sdr_readdata         (sdr_readdata),
    .sdr_readend          (sdr_readend),
    .avm_m0_address       (avm_m0_address),
    .avm_m0_read          (avm_m0_read),
    .avm_m0_readdata      (avm_m0_readdata),
    .avm_m0_readdatavalid (avm_m0_readdatavalid),
    .avm_m0_waitrequest   (avm_m0_waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic start, input logic waitReq, input logic valid,
                               input logic [15:0] data);
    sdr_readstart        = start;
    avm_m0_waitrequest   = waitReq;
    avm_m0_readdatavalid = valid;
    avm_m0_readdata      = valid ? data : 16'hDEAD;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with read high must match the head of the address queue (held while
  // stalled, popped on acceptance); every rising sdr_readend pops a completion record.
  always @(negedge clk) begin
    if (reset) begin
      prevEnd = 1'b0;
    end else begin
      if (avm_m0_read) begin
        if (expAddrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read: got address %h, expected no read", avm_m0_address);
        end else begin
          checkOutput(avm_m0_waitrequest ? "addr_held" : "addr_accept",
                      64'(avm_m0_address), 64'(expAddrQ[0]));
          if (!avm_m0_waitrequest) void'(expAddrQ.pop_front());
        end
      end
      if (sdr_readend && !prevEnd) begin
        if (endQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_end: got sdr_readend 1 at cycle %0d, expected 0", cyc);
        end else begin
          endExp_t e;
          e = endQ.pop_front();
          checkOutput({e.name, "_end_cycle"}, 64'(cyc), 64'(e.riseCyc));
          checkOutput({e.name, "_data_lo64"}, sdr_readdata[63:0], e.lo64);
          checkOutput({e.name, "_slot"}, 64'(sdr_readdata[16*e.slot +: 16]), 64'(e.slotVal));
        end
      end
      prevEnd = sdr_readend;
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    logic        wt1 [12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] dat1[12] = '{0, 0, 0, 20, 0, 30, 40, 0, 50, 0, 0, 0};
    logic [63:0] restartLo;
    logic [15:0] zeroSlot0;

    reset                = 1'b1;
    sdr_readstart        = 1'b0;
    sdr_baseaddr         = 32'd0;
    sdr_nelems           = 30'd0;
    avm_m0_readdata      = 16'hDEAD;
    avm_m0_readdatavalid = 1'b0;
    avm_m0_waitrequest   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_read", 64'(avm_m0_read), 64'd0);
    checkOutput("reset_address", 64'(avm_m0_address), 64'd0);
    checkOutput("reset_data", 64'(|sdr_readdata), 64'd0);
    checkOutput("reset_end", 64'(sdr_readend), 64'd0);
    reset = 1'b0;

    $display("[TB] spurious strobe in IDLE");
    applyStimulus(0, 0, 1, 16'hBEEF);
    applyStimulus(0, 0, 0, 16'h0000);
    checkOutput("idle_strobe_data", 64'(|sdr_readdata), 64'd0);
    checkOutput("idle_strobe_end", 64'(sdr_readend), 64'd0);

    $display("[TB] basic read with stalls");
    sdr_baseaddr = 32'hFFFF_0000;
    sdr_nelems   = 30'd7;
    foreach (dat1[k]) if (k < 4) expAddrQ.push_back(32'(2 * k));
    applyStimulus(1, 0, 0, 16'h0000);
    s = cyc;
    endQ.push_back('{s + 11, 64'h0032_0028_001E_0014, 3, 16'h0032, "basic"});
    sdr_baseaddr = 32'd0;
    sdr_nelems   = 30'd2;
    applyStimulus(0, 0, 0, 16'h0000);
    for (int k = 0; k < 12; k++) applyStimulus(0, wt1[k], dat1[k] != 16'd0, dat1[k]);
    checkOutput("basic_end_high", 64'(sdr_readend), 64'd1);
    checkOutput("basic_read_low", 64'(avm_m0_read), 64'd0);
    repeat (3) applyStimulus(0, 0, 1, 16'h9999);
    checkOutput("basic_end_hold", 64'(sdr_readend), 64'd1);
    checkOutput("basic_done_stable", sdr_readdata[63:0], 64'h0032_0028_001E_0014);

    $display("[TB] restart from DONE");
`ifdef AVALON_SDR_CLEAR_ON_START_EN
    restartLo = 64'h0000_0000_BBBB_AAAA;
`else
    restartLo = 64'h0032_0028_BBBB_AAAA;
`endif
    sdr_baseaddr = 32'h0000_0100;
    sdr_nelems   = 30'd1;
    expAddrQ.push_back(32'h0000_0100);
    expAddrQ.push_back(32'h0000_0102);
    applyStimulus(1, 0, 0, 16'h0000);
    s = cyc;
    endQ.push_back('{s + 5, restartLo, 1, 16'hBBBB, "restart"});
    #3;
    checkOutput("restart_end_drop", 64'(sdr_readend), 64'd0);
    applyStimulus(0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 1, 16'hAAAA);
    applyStimulus(0, 0, 1, 16'hBBBB);
    repeat (3) applyStimulus(0, 0, 0, 16'h0000);
    checkOutput("restart_end_high", 64'(sdr_readend), 64'd1);

    $display("[TB] zero-length read");
`ifdef AVALON_SDR_CLEAR_ON_START_EN
    restartLo = 64'd0;
    zeroSlot0 = 16'h0000;
`else
    zeroSlot0 = 16'hAAAA;
`endif
    sdr_baseaddr = 32'h0000_0200;
    sdr_nelems   = 30'd0;
    applyStimulus(1, 0, 0, 16'h0000);
    s = cyc;
    endQ.push_back('{s + 1, restartLo, 0, zeroSlot0, "zero"});
    repeat (4) applyStimulus(0, 0, 0, 16'h0000);
    checkOutput("zero_end_high", 64'(sdr_readend), 64'd1);

    $display("[TB] clamped read with address wrap");
    sdr_baseaddr = 32'hFFFF_FF80;
    sdr_nelems   = 30'd100;
    for (int i = 0; i < 128; i++) expAddrQ.push_back(32'hFFFF_FF80 + 32'(2 * i));
    applyStimulus(1, 0, 0, 16'h0000);
    s = cyc;
    endQ.push_back('{s + 131, 64'h0003_0002_0001_0000, 127, 16'd127, "clamp"});
    applyStimulus(0, 0, 0, 16'h0000);
    for (int k = 0; k < 132; k++)
      applyStimulus(0, 0, (k >= 1) && (k <= 128), (k >= 1) ? 16'(k - 1) : 16'h0000);
    checkOutput("clamp_end_high", 64'(sdr_readend), 64'd1);
    checkOutput("clamp_slot64", 64'(sdr_readdata[16*64 +: 16]), 64'd64);

    $display("[TB] reset during READ");
    sdr_baseaddr = 32'h0000_0040;
    sdr_nelems   = 30'd4;
    expAddrQ.push_back(32'h0000_0040);
    expAddrQ.push_back(32'h0000_0042);
    applyStimulus(1, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 1, 16'h1111);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_read", 64'(avm_m0_read), 64'd0);
    checkOutput("midreset_address", 64'(avm_m0_address), 64'd0);
    checkOutput("midreset_data", 64'(|sdr_readdata), 64'd0);
    checkOutput("midreset_end", 64'(sdr_readend), 64'd0);
    applyStimulus(0, 0, 1, 16'h5555);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 16'h7777);
    applyStimulus(0, 0, 0, 16'h0000);
    checkOutput("postreset_data", 64'(|sdr_readdata), 64'd0);
    checkOutput("postreset_end", 64'(sdr_readend), 64'd0);
    checkOutput("postreset_read", 64'(avm_m0_read), 64'd0);

    checkOutput("addr_queue_empty", 64'(expAddrQ.size()), 64'd0);
    checkOutput("end_queue_empty", 64'(endQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
